// File: rtl/accumulator_pkg.sv
// Shared types and default widths for the accumulator slice.
package accumulator_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int LEN_WIDTH_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;
endpackage

// File: rtl/accumulator_acc_adder.sv
// Unsigned accumulator adder with carry-out; clamps to all ones on carry
// when ACC_SATURATE_EN is defined, otherwise wraps.
module acc_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  carry_o
);
  logic [ACC_WIDTH:0] full;

  always_comb begin
    full    = {1'b0, acc_i} + {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, data_i};
    carry_o = full[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    sum_o   = carry_o ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
    sum_o   = full[ACC_WIDTH-1:0];
`endif
  end
endmodule

// File: rtl/accumulator.sv
// Frame accumulator with one-entry result register and valid/ready output.
// Optional clamp-on-overflow behaviour selected by ACC_SATURATE_EN.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  clear_i,
  input  logic                  ready_i,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  output logic                  overflow_o,
  output logic                  drop_o,
  output logic                  busy_o
);
  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, data_q, data_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic                   fovf_q, fovf_d, valid_q, valid_d, ovf_q, ovf_d, drop_q, drop_d;
  logic [ACC_WIDTH-1:0]   add_a, sum;
  logic                   carry, frame_ovf, done;

  // First beat of a frame adds onto zero so no separate load path is needed.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  acc_adder #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
    .acc_i  (add_a),
    .data_i (data_i),
    .sum_o  (sum),
    .carry_o(carry)
  );

  assign frame_ovf = ((state_q == ACCUM) && fovf_q) || carry;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    fovf_d  = fovf_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    done    = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      fovf_d  = 1'b0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end else begin
      if (valid_i) begin
        acc_d  = sum;
        fovf_d = frame_ovf;
        if (state_q == IDLE) begin
          count_d = len_i;
          if (len_i == '0) done = 1'b1;
          else             state_d = ACCUM;
        end else begin
          count_d = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      if (valid_q && ready_i) valid_d = 1'b0;
      // A held, unaccepted result wins; the new one is dropped.
      if (done) begin
        if (valid_q && !ready_i) begin
          drop_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = sum;
          ovf_d   = frame_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      fovf_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      fovf_q  <= fovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;
  assign drop_o     = drop_q;
  assign busy_o     = (state_q == ACCUM);
endmodule
